// File: rtl/sn76489_pkg.sv
// Shared constants for the SN76489 sound generator: attenuation curve,
// noise-rate encodings and LFSR geometry.
package sn76489_pkg;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'h0009;
    localparam logic [15:0] DEFAULT_SEED = 16'h8000;

    typedef enum logic [1:0] {
        RATE_16    = 2'b00,
        RATE_32    = 2'b01,
        RATE_64    = 2'b10,
        RATE_TONE3 = 2'b11
    } noise_rate_t;

    // 2 dB per step; code 15 is silence
    function automatic logic [7:0] att_level(input logic [3:0] att);
        logic [7:0] lvl;
        case (att)
            4'd0:    lvl = 8'd255;
            4'd1:    lvl = 8'd203;
            4'd2:    lvl = 8'd161;
            4'd3:    lvl = 8'd128;
            4'd4:    lvl = 8'd102;
            4'd5:    lvl = 8'd81;
            4'd6:    lvl = 8'd64;
            4'd7:    lvl = 8'd51;
            4'd8:    lvl = 8'd40;
            4'd9:    lvl = 8'd32;
            4'd10:   lvl = 8'd26;
            4'd11:   lvl = 8'd20;
            4'd12:   lvl = 8'd16;
            4'd13:   lvl = 8'd13;
            4'd14:   lvl = 8'd10;
            default: lvl = 8'd0;
        endcase
        return lvl;
    endfunction

    function automatic logic [9:0] noise_period(input noise_rate_t rate);
        logic [9:0] p;
        case (rate)
            RATE_32: p = 10'd32;
            RATE_64: p = 10'd64;
            default: p = 10'd16;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sn76489_tone_channel.sv
// One square-wave tone generator: reloadable half-period counter and output
// flip-flop, with periods 0/1 pinning the output high.
module sn76489_tone_channel (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] period,
    output logic       out
);

    logic [9:0] count_reg;
    logic       ff_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= 10'd0;
            ff_reg    <= 1'b0;
        end else if (tick) begin
            if (count_reg <= 10'd1) begin
                count_reg <= period;
                ff_reg    <= ~ff_reg;
            end else begin
                count_reg <= count_reg - 10'd1;
            end
            // PCM mode: the later assignment overrides the toggle above
            if (period <= 10'd1)
                ff_reg <= 1'b1;
        end
    end

    assign out = ff_reg;

endmodule

// File: rtl/sn76489_sound_generator.sv
// SN76489 sound stage: three tone channels, LFSR noise, attenuation and a
// registered four-way mix, all paced by a divide-by-PRESCALE tick.
module sn76489_sound_generator
    import sn76489_pkg::*;
#(
    parameter int          PRESCALE  = 16,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] freq1,
    input  logic [9:0] freq2,
    input  logic [9:0] freq3,
    input  logic [3:0] att1,
    input  logic [3:0] att2,
    input  logic [3:0] att3,
    input  logic [3:0] attNoise,
    input  logic [2:0] noiseControl,
    output logic       tick,
    output logic [7:0] level1,
    output logic [7:0] level2,
    output logic [7:0] level3,
    output logic [7:0] levelNoise,
    output logic [9:0] mix
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     pre_reg;
    logic [9:0]        freq_arr [3];
    logic [3:0]        att_arr  [3];
    logic [7:0]        tone_lvl [3];
    logic [2:0]        tone_out;
    logic [9:0]        noise_cnt_reg;
    logic              noise_ff_reg;
    logic              src_prev_reg;
    logic [2:0]        ctrl_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [7:0]        level_reg [4];
    logic [9:0]        mix_reg;
    noise_rate_t       rate;
    logic              shift_src;
    logic              shift_en;
    logic              fb;
    logic [7:0]        noise_lvl;
    logic [9:0]        mix_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pre_reg <= '0;
        else if (pre_reg == PRE_MAX)
            pre_reg <= '0;
        else
            pre_reg <= pre_reg + PW'(1);
    end

    assign tick = (pre_reg == PRE_MAX);

    assign freq_arr[0] = freq1;
    assign freq_arr[1] = freq2;
    assign freq_arr[2] = freq3;
    assign att_arr[0]  = att1;
    assign att_arr[1]  = att2;
    assign att_arr[2]  = att3;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tone
            sn76489_tone_channel u_tone (
                .clock  (clock),
                .reset  (reset),
                .tick   (tick),
                .period (freq_arr[gi]),
                .out    (tone_out[gi])
            );
            assign tone_lvl[gi] = tone_out[gi] ? att_level(att_arr[gi]) : 8'd0;
        end
    endgenerate

    assign rate = noise_rate_t'(noiseControl[1:0]);

    // Same reload/toggle rule as the tone channels, with a rate-selected period
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            noise_cnt_reg <= 10'd0;
            noise_ff_reg  <= 1'b0;
        end else if (tick) begin
            if (noise_cnt_reg <= 10'd1) begin
                noise_cnt_reg <= noise_period(rate);
                noise_ff_reg  <= ~noise_ff_reg;
            end else begin
                noise_cnt_reg <= noise_cnt_reg - 10'd1;
            end
        end
    end

    assign shift_src = (rate == RATE_TONE3) ? tone_out[2] : noise_ff_reg;
    assign shift_en  = shift_src & ~src_prev_reg;
    assign fb        = noiseControl[2] ? ^(lfsr_reg & LFSR_TAPS) : lfsr_reg[0];

    // A control write restarts the sequence and wins over a coincident shift
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_prev_reg <= 1'b0;
            ctrl_reg     <= 3'd0;
            lfsr_reg     <= LFSR_SEED;
        end else begin
            src_prev_reg <= shift_src;
            ctrl_reg     <= noiseControl;
            if (noiseControl != ctrl_reg)
                lfsr_reg <= LFSR_SEED;
            else if (shift_en)
                lfsr_reg <= {fb, lfsr_reg[LFSR_W-1:1]};
        end
    end

    assign noise_lvl = lfsr_reg[0] ? att_level(attNoise) : 8'd0;
    assign mix_next  = 10'(tone_lvl[0]) + 10'(tone_lvl[1]) + 10'(tone_lvl[2]) + 10'(noise_lvl);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_reg[0] <= 8'd0;
            level_reg[1] <= 8'd0;
            level_reg[2] <= 8'd0;
            level_reg[3] <= 8'd0;
            mix_reg      <= 10'd0;
        end else begin
            level_reg[0] <= tone_lvl[0];
            level_reg[1] <= tone_lvl[1];
            level_reg[2] <= tone_lvl[2];
            level_reg[3] <= noise_lvl;
            mix_reg      <= mix_next;
        end
    end

    assign level1     = level_reg[0];
    assign level2     = level_reg[1];
    assign level3     = level_reg[2];
    assign levelNoise = level_reg[3];
    assign mix        = mix_reg;

endmodule

// File: tb/tb_sn76489_sound_generator.sv
// Directed bench for sn76489_sound_generator; cycle positions are counted in
// clock edges after reset release and outputs are sampled on the falling edge.
module tb_sn76489_sound_generator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] freq1 = 10'd0, freq2 = 10'd0, freq3 = 10'd0;
    logic [3:0] att1 = 4'd15, att2 = 4'd15, att3 = 4'd15, attNoise = 4'd15;
    logic [2:0] noiseControl = 3'd0;
    logic       tick;
    logic [7:0] level1, level2, level3, levelNoise;
    logic [9:0] mix;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [15:0] model;
    logic        mfb;

    sn76489_sound_generator dut (
        .clock        (clock),
        .reset        (reset),
        .freq1        (freq1),
        .freq2        (freq2),
        .freq3        (freq3),
        .att1         (att1),
        .att2         (att2),
        .att3         (att3),
        .attNoise     (attNoise),
        .noiseControl (noiseControl),
        .tick         (tick),
        .level1       (level1),
        .level2       (level2),
        .level3       (level3),
        .levelNoise   (levelNoise),
        .mix          (mix)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %s @edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    endtask

    // Advance to the falling edge following rising edge n after release
    task automatic goto(input int n);
        if (n > edge_n) begin
            repeat (n - edge_n) @(posedge clock);
            edge_n = n;
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        check("rst_level1", 32'(level1), 0);
        check("rst_mix", 32'(mix), 0);
        check("rst_tick", 32'(tick), 0);
        @(negedge clock);
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // 1: tone 1, half-period 4 ticks = 64 clocks
        freq1 = 10'd4; att1 = 4'd0;
        do_reset();
        goto(14);  check("t1_tick_pre", 32'(tick), 0);
        goto(15);  check("t1_tick_first", 32'(tick), 1);
        goto(16);  check("t1_lvl_e16", 32'(level1), 0);
                   check("t1_tick_after", 32'(tick), 0);
        goto(17);  check("t1_lvl_e17", 32'(level1), 255);
                   check("t1_mix_e17", 32'(mix), 255);
        goto(80);  check("t1_lvl_e80", 32'(level1), 255);
        goto(81);  check("t1_lvl_e81", 32'(level1), 0);
                   check("t1_mix_e81", 32'(mix), 0);
        goto(144); check("t1_lvl_e144", 32'(level1), 0);
        goto(145); check("t1_lvl_e145", 32'(level1), 255);

        // 2: PCM mode on tone 2
        att1 = 4'd15; freq2 = 10'd1; att2 = 4'd3;
        do_reset();
        goto(16);  check("t2_lvl_e16", 32'(level2), 0);
        goto(17);  check("t2_lvl_e17", 32'(level2), 128);
                   check("t2_mix_e17", 32'(mix), 128);
        goto(100); check("t2_lvl_e100", 32'(level2), 128);
        goto(200); check("t2_lvl_e200", 32'(level2), 128);
        att2 = 4'd15;
        goto(201); check("t2_lvl_off", 32'(level2), 0);
                   check("t2_mix_off", 32'(mix), 0);

        // 3: periodic noise at rate 16, 512 clocks per shift
        noiseControl = 3'b000; attNoise = 4'd0;
        do_reset();
        goto(17);   check("t3_noise_e17", 32'(levelNoise), 0);
        goto(7185); check("t3_noise_pre15", 32'(levelNoise), 0);
        goto(7186); check("t3_noise_shift15", 32'(levelNoise), 255);
                    check("t3_mix_shift15", 32'(mix), 255);
        goto(7697); check("t3_noise_hold", 32'(levelNoise), 255);
        goto(7698); check("t3_noise_shift16", 32'(levelNoise), 0);

        // 4: white noise clocked by tone 3 rising edges (every 64 clocks)
        noiseControl = 3'b111; freq3 = 10'd2;
        do_reset();
        model = 16'h8000;
        for (int k = 1; k <= 24; k++) begin
            goto(18 + 64 * (k - 1));
            mfb   = model[0] ^ model[3];
            model = {mfb, model[15:1]};
            check($sformatf("t4_white_shift%0d", k), 32'(levelNoise), model[0] ? 255 : 0);
        end

        // 5: control write mid-sequence reseeds the LFSR
        noiseControl = 3'b100; freq3 = 10'd0;
        do_reset();
        goto(7200); check("t5_noise_before", 32'(levelNoise), 255);
        noiseControl = 3'b101;
        goto(7201); check("t5_noise_e7201", 32'(levelNoise), 255);
        goto(7202); check("t5_noise_reseed", 32'(levelNoise), 0);
                    check("t5_mix_reseed", 32'(mix), 0);

        // 6: asynchronous reset while tones are running
        noiseControl = 3'b000; freq1 = 10'd4; att1 = 4'd0; freq3 = 10'd2; att3 = 4'd0;
        do_reset();
        goto(31);  check("t6_tick_live", 32'(tick), 1);
                   check("t6_mix_live", 32'(mix), 510);
        reset = 1'b1;
        #1;
        check("t6_async_level1", 32'(level1), 0);
        check("t6_async_level3", 32'(level3), 0);
        check("t6_async_mix", 32'(mix), 0);
        check("t6_async_tick", 32'(tick), 0);
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
        edge_n = 0;
        goto(14);  check("t6_tick_pre", 32'(tick), 0);
        goto(15);  check("t6_tick_first", 32'(tick), 1);
        goto(16);  check("t6_lvl1_e16", 32'(level1), 0);
        goto(17);  check("t6_lvl1_e17", 32'(level1), 255);
                   check("t6_mix_e17", 32'(mix), 510);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
